// File: rtl/frame_pkg.sv
// Shared definitions for the frame reduction slice.
//   DEFAULT_WIDTH : default sample width (bits)
//   state_t       : frame_max_finder control states (ST_ACCUM / ST_DONE)
package frame_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/comparator_gt.sv
// comparator_gt: signed magnitude comparator.
// Ports:
//   a, b : WIDTH-bit two's-complement operands
//   gt   : 1 when a > b (signed, strict)
module comparator_gt
  import frame_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  assign gt = $signed(a) > $signed(b);

endmodule

// File: rtl/frame_max_finder.sv
// frame_max_finder: groups a signed sample stream into FRAME_LEN-sample
// frames and reports the largest sample of each frame and its 0-based
// position (ties keep the earlier position).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : sample handshake, in_data is the signed sample
//   out_valid/out_ready  : result handshake
//   out_max, out_idx     : frame maximum and its index, held until the
//                          next frame completes
//   out_min              : frame minimum (only with FRAME_MIN_TRACK_EN)
// Optional feature macro: FRAME_MIN_TRACK_EN adds minimum tracking.
module frame_max_finder
  import frame_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx
`ifdef FRAME_MIN_TRACK_EN
  ,
  output logic [WIDTH-1:0] out_min
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] max_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] max_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             max_gt;
  logic             in_acc;
  logic             out_acc;
  logic             first;
  logic             last;

  assign in_ready  = (state == ST_ACCUM) && !rst;
  assign out_valid = (state == ST_DONE);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign first     = (cnt == '0);
  assign last      = (cnt == LAST_IDX);

  comparator_gt #(.WIDTH(WIDTH)) u_max_cmp (
    .a  (in_data),
    .b  (max_r),
    .gt (max_gt)
  );

  // The running maximum including the current sample is formed here so the
  // final sample of a frame can be published straight into out_max/out_idx.
  always_comb begin
    max_nxt = max_r;
    idx_nxt = idx_r;
    if (first) begin
      max_nxt = in_data;
      idx_nxt = '0;
    end else if (max_gt) begin
      max_nxt = in_data;
      idx_nxt = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (in_acc && last) state_nxt = ST_DONE;
      ST_DONE:  if (out_acc)        state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      max_r   <= '0;
      idx_r   <= '0;
      out_max <= '0;
      out_idx <= '0;
    end else if (in_acc) begin
      cnt   <= last ? '0 : cnt + 1'b1;
      max_r <= max_nxt;
      idx_r <= idx_nxt;
      if (last) begin
        out_max <= max_nxt;
        out_idx <= idx_nxt;
      end
    end
  end

`ifdef FRAME_MIN_TRACK_EN
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] min_nxt;
  logic             min_gt;

  comparator_gt #(.WIDTH(WIDTH)) u_min_cmp (
    .a  (min_r),
    .b  (in_data),
    .gt (min_gt)
  );

  always_comb begin
    min_nxt = min_r;
    if (first || min_gt) begin
      min_nxt = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_r   <= '0;
      out_min <= '0;
    end else if (in_acc) begin
      min_r <= min_nxt;
      if (last) begin
        out_min <= min_nxt;
      end
    end
  end
`endif

endmodule

// File: doc/frame_max_finder.md
Name: frame_max_finder

Overview:
- Streaming reduction stage that sits directly downstream of the 32-bit signed magnitude comparator.
- Accepts a stream of signed samples over a valid/ready handshake and groups them into fixed-length frames.
- For each frame, tracks the largest sample and its position within the frame.
- Presents one result per frame on a valid/ready output handshake.

Parameters:
- WIDTH, 32, sample width in bits; samples are two's-complement signed.
- FRAME_LEN, 8, samples per frame; must be ≥ 2.
- IDX_W, 3, index width; must satisfy 2^IDX_W ≥ FRAME_LEN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  signed sample.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts result.
- out_max  output  WIDTH  largest sample of the frame (signed).
- out_idx  output  IDX_W  position in frame (0-based) of out_max.

Behaviour:
- Reset state:
  - Asynchronous assert forces state ACCUM, cnt=0, out_valid=0, out_max=0, out_idx=0.
  - in_ready=0 while rst is high.
- Interface timing:
  - in_ready = (state==ACCUM) && !rst. It is combinational from state and does not depend on in_valid.
  - Sample accept = in_valid && in_ready. Result accept = out_valid && out_ready.
- States: ACCUM, DONE.
- ACCUM, on each accepted sample:
  - If cnt==0: load max_r=in_data and idx_r=0 unconditionally.
  - Otherwise, if in_data > max_r (signed, strict): max_r=in_data and idx_r=cnt.
  - Ties keep the earlier index.
  - cnt increments by 1.
- Frame completion:
  - Accepting the sample with cnt==FRAME_LEN-1 sets cnt=0, enters DONE and sets out_valid=1 on the next edge.
  - The last sample takes part in the comparison, so its result is included in out_max/out_idx.
- DONE:
  - in_ready=0. out_valid, out_max and out_idx hold stable until accepted.
  - On result accept: out_valid=0 and state returns to ACCUM on the next edge.
  - There is no same-cycle input/output overlap.
- Latency and throughput:
  - out_valid rises 1 cycle after the last sample is accepted.
  - Minimum frame period is FRAME_LEN+1 cycles.
- Comparison:
  - Performed by one instance of comparator_gt, with a=in_data and b=max_r.
  - Signed semantics: -5 > -6; 5 > -6.
- Bubbles: in_valid low in ACCUM changes no state, and cnt holds.
- Output stability: out_max and out_idx remain stable after accept until the next frame completes.
- Reset mid-frame: the partial frame is discarded. After release, the first accepted sample is index 0.
- Reset in DONE: the pending result is lost and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: FRAME_MIN_TRACK_EN.
- When defined:
  - Adds output port out_min (WIDTH, signed) and a second comparator_gt instance (a=min_r, b=in_data).
  - On cnt==0, min_r loads in_data. Afterwards min_r updates when min_r > in_data (strict).
  - out_min is presented and held alongside out_max. Reset value is 0.
- When undefined: no port, no extra logic. Behaviour is otherwise identical.

Decomposition:
- Shared package frame_pkg contains:
  - state encoding constants ST_ACCUM=1'b0, ST_DONE=1'b1;
  - default WIDTH=32.
- Sub-module: the existing comparator_gt is instantiated (once, or twice with FRAME_MIN_TRACK_EN). No new sub-module.

Test Plan (FRAME_LEN=4, IDX_W=2):
- Reset, then samples 12381, 8484, 3, 7 with in_valid held high and out_ready=1 → out_valid one cycle after the 4th sample; out_max=12381, out_idx=0; out_valid drops the following cycle.
- Negative values: samples -6, -5, -9, -5 → out_max=-5, out_idx=1 (tie keeps earlier index); with FRAME_MIN_TRACK_EN, out_min=-9.
- Mixed sign: samples -6, 5, -6, 4 → out_max=5, out_idx=1.
- Backpressure: out_ready=0 for 5 cycles after completion → out_valid, out_max and out_idx stable; in_ready=0 throughout; in_valid samples are not consumed.
- Bubbles: valid samples 1, 2 with idle cycles between, then 9, 0 → out_max=9, out_idx=2.
- Reset mid-frame: two samples 100, 200, pulse rst, then 1, 2, 3, 4 → out_max=4, out_idx=3; 100 and 200 are never reported.
